// File: rtl/spi_master_multi_if.sv
// spi_master_multi_if: SPI bus, FIFO handshake and run-time config
// bundle shared between the multi-slave SPI master and its user.
interface spi_master_multi_if #(
   parameter int DATA_W  = 8,
   parameter int N_CS    = 4,
   parameter int DIV_W   = 8,
   parameter int FRAME_W = 8
);
   localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1;

   logic               sclk;
   logic [N_CS-1:0]    n_cs;
   logic               mosi;
   logic               miso;
   logic               cpol;
   logic               cpha;
   logic [DIV_W-1:0]   clk_div;
   logic [CS_W-1:0]    cs_sel;
   logic [FRAME_W-1:0] frame_len;
   logic               rx_en;
   logic               empty;
   logic [DATA_W-1:0]  data_i;
   logic               rdreq;
   logic [DATA_W-1:0]  miso_word;
   logic               wrreq;
   logic               busy;

   modport master (
      input  miso, cpol, cpha, clk_div, cs_sel, frame_len,
      input  rx_en, empty, data_i,
      output sclk, n_cs, mosi, rdreq, miso_word, wrreq, busy
   );

   modport slave (
      output miso, cpol, cpha, clk_div, cs_sel, frame_len,
      output rx_en, empty, data_i,
      input  sclk, n_cs, mosi, rdreq, miso_word, wrreq, busy
   );
endinterface

// File: rtl/spi_master_multi.sv
// spi_master_multi: FIFO-fed SPI master for several slaves with
// run-time word mode/divider/frame length and CS setup/hold/gap timing.
module spi_master_multi #(
   parameter int DATA_W  = 8,
   parameter int N_CS    = 4,
   parameter int DIV_W   = 8,
   parameter int FRAME_W = 8,
   parameter int CS_GAP  = 2
) (
   input  logic               clk,
   input  logic               n_rst,
   spi_master_multi_if.master m_if
);
   localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1;
   localparam int PW   = (DIV_W < 3) ? 3 : DIV_W;
   localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GW   = $clog2(CS_GAP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
   } state_t;

   state_t             r_state;
   state_t             w_state_n;
   logic               r_cpol;
   logic               r_cpha;
   logic [PW-1:0]      r_d;
   logic [FRAME_W-1:0] r_flen;
   logic [FRAME_W-1:0] r_cnt;
   logic [PW-1:0]      r_phase;
   logic [BW-1:0]      r_bit;
   logic [GW-1:0]      r_gap;
   logic [DATA_W-1:0]  r_sh;
   logic [DATA_W-1:0]  r_rx;
   logic [DATA_W-1:0]  r_word;
   logic [N_CS-1:0]    r_ncs;
   logic               r_sclk;
   logic               r_mosi;
   logic               r_rdreq;
   logic               r_wrreq;

   logic [PW-1:0]      w_deven;
   logic [PW-1:0]      w_d;
   logic [PW-1:0]      w_hm1;
   logic [PW-1:0]      w_dm1;
   logic               w_lead;
   logic               w_last_ph;
   logic               w_last_bit;
   logic               w_word_end;
   logic               w_samp;
   logic               w_stop;
   logic [FRAME_W-1:0] w_cnt_n;
   logic [DATA_W-1:0]  w_rx_n;

   // Odd dividers round down; anything below 4 would leave no room
   // for separate leading and trailing phases.
   assign w_deven    = PW'(m_if.clk_div) & ~PW'(1);
   assign w_d        = (w_deven < PW'(4)) ? PW'(4) : w_deven;
   assign w_hm1      = (r_d >> 1) - PW'(1);
   assign w_dm1      = r_d - PW'(1);
   assign w_lead     = (r_phase == w_hm1);
   assign w_last_ph  = (r_phase == w_dm1);
   assign w_last_bit = (r_bit == BW'(DATA_W - 1));
   assign w_word_end = (r_state == S_SHIFT) && w_last_ph && w_last_bit;
   assign w_samp     = (r_state == S_SHIFT) &&
                       (r_cpha ? w_last_ph : w_lead);
   assign w_cnt_n    = r_cnt + FRAME_W'(1);
   assign w_stop     = ((r_flen != '0) && (w_cnt_n == r_flen)) ||
                       m_if.empty;
   assign w_rx_n     = {r_rx[DATA_W-2:0], m_if.miso};

   assign m_if.sclk      = r_sclk;
   assign m_if.n_cs      = r_ncs;
   assign m_if.mosi      = r_mosi;
   assign m_if.rdreq     = r_rdreq;
   assign m_if.wrreq     = r_wrreq;
   assign m_if.miso_word = r_word;
   assign m_if.busy      = (r_state != S_IDLE);

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_state_n;
   end

   // Next-state decode
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  if (!m_if.empty)          w_state_n = S_SETUP;
         S_SETUP: if (w_lead)               w_state_n = S_SHIFT;
         S_SHIFT: if (w_word_end && w_stop) w_state_n = S_HOLD;
         S_HOLD:  if (w_lead)               w_state_n = S_GAP;
         S_GAP:   if (r_gap == GW'(CS_GAP - 1))
                                            w_state_n = S_IDLE;
         default:                           w_state_n = S_IDLE;
      endcase
   end

   // Frame datapath: config capture, sclk/phase timing, shift regs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_d     <= PW'(4);
         r_flen  <= '0;
         r_cnt   <= '0;
         r_phase <= '0;
         r_bit   <= '0;
         r_gap   <= '0;
         r_sh    <= '0;
         r_rx    <= '0;
         r_word  <= '0;
         r_ncs   <= '1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_rdreq <= 1'b0;
         r_wrreq <= 1'b0;
      end else begin
         r_rdreq <= 1'b0;
         r_wrreq <= 1'b0;
         if (w_samp) r_rx <= w_rx_n;
         case (r_state)
            S_IDLE: begin
               r_sclk  <= m_if.cpol;
               r_phase <= '0;
               r_bit   <= '0;
               r_gap   <= '0;
               r_cnt   <= '0;
               if (!m_if.empty) begin
                  r_cpol  <= m_if.cpol;
                  r_cpha  <= m_if.cpha;
                  r_d     <= w_d;
                  r_flen  <= m_if.frame_len;
                  r_sh    <= m_if.data_i;
                  r_rdreq <= 1'b1;
                  if (!m_if.cpha) r_mosi <= m_if.data_i[DATA_W-1];
                  for (int i = 0; i < N_CS; i++)
                     r_ncs[i] <= (m_if.cs_sel != CS_W'(i));
               end
            end
            S_SETUP: begin
               r_phase <= w_lead ? '0 : r_phase + PW'(1);
            end
            S_SHIFT: begin
               r_phase <= w_last_ph ? '0 : r_phase + PW'(1);
               if (w_lead) r_sclk <= ~r_cpol;
               if (w_last_ph) r_sclk <= r_cpol;
               if (r_cpha && w_lead) begin
                  r_mosi <= r_sh[DATA_W-1];
                  r_sh   <= r_sh << 1;
               end
               if (w_last_ph && !w_last_bit) begin
                  r_bit <= r_bit + BW'(1);
                  if (!r_cpha) begin
                     r_mosi <= r_sh[DATA_W-2];
                     r_sh   <= r_sh << 1;
                  end
               end
               if (w_word_end) begin
                  r_bit   <= '0;
                  r_word  <= r_cpha ? w_rx_n : r_rx;
                  r_wrreq <= m_if.rx_en;
                  r_cnt   <= w_cnt_n;
                  if (!w_stop) begin
                     r_sh    <= m_if.data_i;
                     r_rdreq <= 1'b1;
                     if (!r_cpha) r_mosi <= m_if.data_i[DATA_W-1];
                  end
               end
            end
            S_HOLD: begin
               r_phase <= w_lead ? '0 : r_phase + PW'(1);
               if (w_lead) r_ncs <= '1;
            end
            S_GAP: begin
               r_gap <= r_gap + GW'(1);
            end
            default: r_ncs <= '1;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: vector table plus corner sequences, with a TX
// FIFO model, an SPI slave model and word scoreboards.
module tb_spi_master_multi;
   localparam int CSG = 2;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   spi_master_multi_if #(.DATA_W(8), .N_CS(4), .DIV_W(8), .FRAME_W(8)) bus ();

   spi_master_multi #(
      .DATA_W(8), .N_CS(4), .DIV_W(8), .FRAME_W(8), .CS_GAP(CSG)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .m_if (bus)
   );

   typedef struct {
      logic            cpol;
      logic            cpha;
      logic [7:0]      div;
      logic [1:0]      cs;
      logic [7:0]      flen;
      int              n;
      logic            rxen;
      logic            lp;
      logic [2:0][7:0] tw;
      logic [2:0][7:0] sw;
      int              low;
      logic [3:0]      ncs;
   } vec_t;

   vec_t vecs[8];

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] tx_q[$];
   logic [7:0] sw_q[$];
   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_tx_q[$];

   logic loop = 1'b0;
   logic s_cpol = 1'b0;
   logic s_cpha = 1'b0;
   logic s_chk = 1'b1;
   logic s_miso = 1'b0;
   logic [7:0] s_sh = 8'h00;
   logic [7:0] s_rx = 8'h00;
   int s_n = 0;
   int s_oc = 0;

   int cs_low = 0;
   int lead_cnt = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int hi_run = 0;
   int gap_seen = 0;
   logic [3:0] ncs_seen = 4'hF;
   logic prev_sclk = 1'b0;
   logic prev_act = 1'b0;

   assign bus.miso = loop ? bus.mosi : s_miso;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [7:0] pop_sw();
      if (sw_q.size() != 0) return sw_q.pop_front();
      return 8'h00;
   endfunction

   // TX FIFO model: show-ahead, pops on rdreq
   always @(negedge clk) begin
      if (bus.rdreq) begin
         rd_cnt++;
         check("rdreq_nonempty", 32'(tx_q.size() != 0), 1);
         if (tx_q.size() != 0) void'(tx_q.pop_front());
      end
      bus.empty  = (tx_q.size() == 0);
      bus.data_i = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
   end

   // Bus monitor, RX scoreboard and SPI slave model
   always @(negedge clk) begin
      logic act;
      logic lead;
      logic samp;
      act = (bus.n_cs != 4'hF);
      if (act) begin
         cs_low++;
         ncs_seen = bus.n_cs;
      end
      if (!act) hi_run++;
      else if (!prev_act) begin
         gap_seen = hi_run;
         hi_run = 0;
      end
      if (act && bus.sclk != prev_sclk && bus.sclk != s_cpol)
         lead_cnt++;
      if (bus.wrreq) begin
         wr_cnt++;
         if (exp_rx_q.size() == 0) fail("unexpected_wrreq");
         else check("rx_word", bus.miso_word, exp_rx_q.pop_front());
      end
      if (act && !prev_act) begin
         s_n = 0;
         s_oc = 0;
         if (!s_cpha) begin
            s_sh = pop_sw();
            s_miso = s_sh[7];
            s_oc = 1;
         end
      end
      if (act && bus.sclk != prev_sclk) begin
         lead = (bus.sclk != s_cpol);
         samp = s_cpha ? !lead : lead;
         if (samp) begin
            s_rx = {s_rx[6:0], bus.mosi};
            s_n++;
            if (s_n == 8) begin
               s_n = 0;
               if (s_chk) begin
                  if (exp_tx_q.size() == 0) fail("unexpected_mosi_word");
                  else check("mosi_word", s_rx, exp_tx_q.pop_front());
               end
            end
         end else if (s_cpha) begin
            if (s_oc == 0) s_sh = pop_sw();
            s_miso = s_sh[7];
            s_sh = s_sh << 1;
            s_oc = (s_oc == 7) ? 0 : s_oc + 1;
         end else if (s_oc == 8) begin
            s_sh = pop_sw();
            s_miso = s_sh[7];
            s_oc = 1;
         end else begin
            s_sh = s_sh << 1;
            s_miso = s_sh[7];
            s_oc++;
         end
      end
      prev_sclk = bus.sclk;
      prev_act = act;
   end

   task automatic clr_cnt();
      cs_low = 0;
      lead_cnt = 0;
      rd_cnt = 0;
      wr_cnt = 0;
      ncs_seen = 4'hF;
   endtask

   task automatic set_cfg(input vec_t v);
      bus.cpol = v.cpol;
      bus.cpha = v.cpha;
      bus.clk_div = v.div;
      bus.cs_sel = v.cs;
      bus.frame_len = v.flen;
      bus.rx_en = v.rxen;
      s_cpol = v.cpol;
      s_cpha = v.cpha;
      loop = v.lp;
   endtask

   task automatic wait_busy(input string tag, input logic lvl,
                            input int lim);
      int t;
      t = 0;
      while (bus.busy != lvl && t < lim) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= lim) fail({tag, "_busy_timeout"});
   endtask

   task automatic wait_cs(input string tag, input logic low,
                          input int lim);
      int t;
      t = 0;
      while ((bus.n_cs != 4'hF) != low && t < lim) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= lim) fail({tag, "_cs_timeout"});
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(posedge clk); #1;
      set_cfg(v);
      s_chk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_idle_sclk_pre"}, bus.sclk, v.cpol);
      clr_cnt();
      for (int i = 0; i < v.n; i++) begin
         exp_tx_q.push_back(v.tw[i]);
         sw_q.push_back(v.sw[i]);
         if (v.rxen) exp_rx_q.push_back(v.lp ? v.tw[i] : v.sw[i]);
         tx_q.push_back(v.tw[i]);
      end
      wait_busy(tag, 1'b1, 50);
      wait_busy(tag, 1'b0, 3000);
      @(negedge clk);
      check({tag, "_cs_low_cycles"}, cs_low, v.low);
      check({tag, "_n_cs"}, ncs_seen, v.ncs);
      check({tag, "_sclk_edges"}, lead_cnt, v.n * 8);
      check({tag, "_rdreq_cnt"}, rd_cnt, v.n);
      check({tag, "_wrreq_cnt"}, wr_cnt, v.rxen ? v.n : 0);
      check({tag, "_rx_left"}, exp_rx_q.size(), 0);
      check({tag, "_tx_left"}, exp_tx_q.size(), 0);
      check({tag, "_idle_sclk_post"}, bus.sclk, v.cpol);
   endtask

   task automatic chk_reset_vals(input string tag);
      check({tag, "_sclk"}, bus.sclk, 0);
      check({tag, "_n_cs"}, bus.n_cs, 4'hF);
      check({tag, "_mosi"}, bus.mosi, 0);
      check({tag, "_rdreq"}, bus.rdreq, 0);
      check({tag, "_wrreq"}, bus.wrreq, 0);
      check({tag, "_miso_word"}, bus.miso_word, 0);
      check({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{1'b0, 1'b0, 8'd8,  2'd0, 8'd2, 2, 1'b1, 1'b1,
                  24'h003CA5, 24'h000000, 136, 4'hE};
      vecs[1] = '{1'b0, 1'b1, 8'd8,  2'd1, 8'd1, 1, 1'b1, 1'b0,
                  24'h00005A, 24'h000096, 72, 4'hD};
      vecs[2] = '{1'b1, 1'b0, 8'd6,  2'd3, 8'd1, 1, 1'b1, 1'b0,
                  24'h000069, 24'h000096, 54, 4'h7};
      vecs[3] = '{1'b1, 1'b1, 8'd10, 2'd0, 8'd1, 1, 1'b1, 1'b0,
                  24'h0000C3, 24'h000096, 90, 4'hE};
      vecs[4] = '{1'b0, 1'b0, 8'd4,  2'd2, 8'd0, 3, 1'b1, 1'b0,
                  24'h332211, 24'hE718C3, 100, 4'hB};
      vecs[5] = '{1'b0, 1'b1, 8'd5,  2'd1, 8'd1, 1, 1'b1, 1'b0,
                  24'h00000F, 24'h0000F0, 36, 4'hD};
      vecs[6] = '{1'b1, 1'b0, 8'd2,  2'd2, 8'd1, 1, 1'b1, 1'b0,
                  24'h000081, 24'h00007E, 36, 4'hB};
      vecs[7] = '{1'b0, 1'b0, 8'd8,  2'd3, 8'd1, 1, 1'b0, 1'b0,
                  24'h000055, 24'h0000AA, 72, 4'h7};

      set_cfg(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      n_rst = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Two back-to-back single-word frames; cpol flips mid frame 1
      v = vecs[0];
      v.flen = 8'd1;
      @(posedge clk); #1;
      set_cfg(v);
      s_chk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      clr_cnt();
      tx_q.push_back(8'h81);
      tx_q.push_back(8'h7E);
      exp_rx_q.push_back(8'h81);
      exp_rx_q.push_back(8'h7E);
      wait_cs("f1", 1'b1, 50);
      repeat (20) @(posedge clk);
      #1;
      bus.cpol = 1'b1;
      wait_cs("f1", 1'b0, 200);
      check("f1_sclk_after", bus.sclk, 0);
      wait_cs("f2", 1'b1, 50);
      check("f2_gap_ok", 32'(gap_seen >= CSG), 1);
      check("f2_sclk_idle", bus.sclk, 1);
      wait_busy("f2", 1'b0, 3000);
      @(negedge clk);
      check("f12_wrreq_cnt", wr_cnt, 2);
      check("f12_rdreq_cnt", rd_cnt, 2);
      check("f12_rx_left", exp_rx_q.size(), 0);

      // Abort with reset in the middle of bit 3
      v = vecs[0];
      v.flen = 8'd1;
      @(posedge clk); #1;
      set_cfg(v);
      repeat (3) @(posedge clk);
      #1;
      clr_cnt();
      tx_q.push_back(8'hC6);
      wait_cs("rst", 1'b1, 50);
      repeat (4 + 3 * 8 + 4) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk_reset_vals("abort");
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("abort_hold");
      @(negedge clk);
      n_rst = 1'b1;
      exp_rx_q.delete();
      exp_tx_q.delete();
      sw_q.delete();
      repeat (4) @(posedge clk);
      #1;
      check("abort_rdreq_cnt", rd_cnt, 1);
      check("abort_wrreq_cnt", wr_cnt, 0);
      run_vec(vecs[0], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
